// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared definitions for the LED sequencer: configuration field
//            widths, mode encoding, per-channel state encoding and a helper
//            that decodes the LED level from a channel state.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package led_pkg;

    // Configuration field widths
    localparam int c_CH_W   = 3;
    localparam int c_MODE_W = 2;

    // Configuration mode encoding
    typedef enum logic [c_MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } led_mode_t;

    // Per-channel state encoding
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_ON       = 3'd1,
        ST_BLINK_HI = 3'd2,
        ST_BLINK_LO = 3'd3,
        ST_BURST_HI = 3'd4,
        ST_BURST_LO = 3'd5
    } ch_state_t;

    // LED is lit in the steady-on state and in the high half of blink/burst
    function automatic logic state_led(input ch_state_t s);
        return (s == ST_ON) || (s == ST_BLINK_HI) || (s == ST_BURST_HI);
    endfunction

    // A burst is in progress in either half of a burst pulse
    function automatic logic state_busy(input ch_state_t s);
        return (s == ST_BURST_HI) || (s == ST_BURST_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer_if
// Purpose  : Configuration write channel of the LED sequencer (valid/ready
//            handshake plus channel, mode, half-period and burst count).
// Ports    : cfg_valid  - write request            (master -> slave)
//            cfg_ready  - write can be accepted    (slave  -> master)
//            cfg_ch     - target channel index     (master -> slave)
//            cfg_mode   - OFF / ON / BLINK / BURST (master -> slave)
//            cfg_period - half-period in ticks     (master -> slave)
//            cfg_count  - burst pulse count        (master -> slave)
// Revision : 1.0  initial release
// ============================================================================
interface led_sequencer_if #(
    parameter int PER_W = 16,
    parameter int CNT_W = 8
);
    import led_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [c_CH_W-1:0]   cfg_ch;
    logic [c_MODE_W-1:0] cfg_mode;
    logic [PER_W-1:0]    cfg_period;
    logic [CNT_W-1:0]    cfg_count;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_period,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_period,
        input  cfg_count,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module   : led_channel
// Purpose  : One LED channel: state machine (OFF/ON/BLINK/BURST), phase
//            counter advanced by the shared tick, and burst pulse counter.
// Ports    : clk50  - system clock
//            rst    - synchronous active-high reset
//            tick   - one-cycle timebase pulse shared by all channels
//            wr     - accepted configuration write for this channel
//            mode   - new mode (valid with wr)
//            period - new half-period in ticks, 0 treated as 1 (with wr)
//            count  - new burst pulse count (with wr)
//            led    - registered LED drive
//            busy   - high while a burst is in progress
// Revision : 1.0  initial release
// ============================================================================
module led_channel
    import led_pkg::*;
#(
    parameter int PER_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic                tick,
    input  logic                wr,
    input  logic [c_MODE_W-1:0] mode,
    input  logic [PER_W-1:0]    period,
    input  logic [CNT_W-1:0]    count,
    output logic                led,
    output logic                busy
);

    ch_state_t        r_state, w_state;
    logic [PER_W-1:0] r_phase, w_phase;
    logic [PER_W-1:0] r_period, w_period;
    logic [CNT_W-1:0] r_remain, w_remain;
    logic             r_led, w_led;
    logic             r_busy, w_busy;
    logic             w_phase_end;

    // Latched period is never 0, so period-1 is always a reachable phase
    assign w_phase_end = (r_phase == (r_period - PER_W'(1)));

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_phase  <= '0;
            r_period <= '0;
            r_remain <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_phase  <= w_phase;
            r_period <= w_period;
            r_remain <= w_remain;
            r_led    <= w_led;
            r_busy   <= w_busy;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_phase  = r_phase;
        w_period = r_period;
        w_remain = r_remain;

        if (wr) begin
            // A write always wins over a coincident tick and restarts timing
            w_phase  = '0;
            w_period = (period == '0) ? PER_W'(1) : period;
            w_remain = count;
            case (led_mode_t'(mode))
                MODE_OFF:   w_state = ST_OFF;
                MODE_ON:    w_state = ST_ON;
                MODE_BLINK: w_state = ST_BLINK_HI;
                MODE_BURST: w_state = (count == '0) ? ST_OFF : ST_BURST_HI;
                default:    w_state = ST_OFF;
            endcase
        end else if (tick) begin
            case (r_state)
                ST_BLINK_HI, ST_BLINK_LO, ST_BURST_HI, ST_BURST_LO: begin
                    if (w_phase_end) begin
                        w_phase = '0;
                        case (r_state)
                            ST_BLINK_HI: w_state = ST_BLINK_LO;
                            ST_BLINK_LO: w_state = ST_BLINK_HI;
                            ST_BURST_HI: w_state = ST_BURST_LO;
                            default: begin
                                // End of a burst low half: next pulse or done
                                if (r_remain > CNT_W'(1)) begin
                                    w_remain = r_remain - CNT_W'(1);
                                    w_state  = ST_BURST_HI;
                                end else begin
                                    w_remain = '0;
                                    w_state  = ST_OFF;
                                end
                            end
                        endcase
                    end else begin
                        w_phase = r_phase + PER_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they track it exactly
        w_led  = state_led(w_state);
        w_busy = state_busy(w_state);
    end

    assign led  = r_led;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer
// Purpose  : Multi-channel LED sequencer. A shared prescaler produces a
//            timebase tick; configuration writes are decoded to one of
//            NUM_CH led_channel instances.
// Ports    : clk50 - system clock (single clock domain)
//            rst   - synchronous active-high reset
//            cfg   - configuration write interface (slave side)
//            led   - registered LED drive, bit i = channel i
//            busy  - bit i high while channel i runs a burst
// Revision : 1.0  initial release
// ============================================================================
module led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int TICK_DIV = 50000,
    parameter int PER_W    = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk50,
    input  logic              rst,
    led_sequencer_if.slave    cfg,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy
);

    localparam int c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;
    logic                 r_acc;
    logic                 w_accept;
    logic [NUM_CH-1:0]    w_wr;

    // Prescaler: tick is the last count before the wrap
    assign w_tick = (r_presc == c_PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // Ready drops for the single cycle after an acceptance; gating with rst
    // keeps ready low during reset so a write presented then is ignored.
    assign cfg.cfg_ready = ~rst & ~r_acc;
    assign w_accept      = cfg.cfg_valid & cfg.cfg_ready;

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_acc <= 1'b0;
        end else begin
            r_acc <= w_accept;
        end
    end

    // Out-of-range channel indices match no instance and are dropped
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_wr[i] = w_accept && (cfg.cfg_ch == c_CH_W'(i));

            led_channel #(
                .PER_W (PER_W),
                .CNT_W (CNT_W)
            ) u_channel (
                .clk50  (clk50),
                .rst    (rst),
                .tick   (w_tick),
                .wr     (w_wr[i]),
                .mode   (cfg.cfg_mode),
                .period (cfg.cfg_period),
                .count  (cfg.cfg_count),
                .led    (led[i]),
                .busy   (busy[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequencer
// Purpose  : Self-checking bench for led_sequencer (NUM_CH=2, TICK_DIV=4).
//            A reference model tracks, per channel, the mode, parameters and
//            ticks elapsed since the last write, and derives the expected
//            LED/busy levels arithmetically from those.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_sequencer;

    localparam int NUM_CH   = 2;
    localparam int TICK_DIV = 4;
    localparam int PER_W    = 16;
    localparam int CNT_W    = 8;

    logic              clk50 = 1'b0;
    logic              rst   = 1'b1;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;

    led_sequencer_if #(.PER_W(PER_W), .CNT_W(CNT_W)) cfg_if ();

    led_sequencer #(
        .NUM_CH   (NUM_CH),
        .TICK_DIV (TICK_DIV),
        .PER_W    (PER_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk50 (clk50),
        .rst   (rst),
        .cfg   (cfg_if),
        .led   (led),
        .busy  (busy)
    );

    always #5 clk50 = ~clk50;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mode [NUM_CH];
    int m_per  [NUM_CH];
    int m_cnt  [NUM_CH];
    int m_t    [NUM_CH];
    int m_cyc  = 0;
    bit m_prev_acc = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs: blink/burst half index is ticks elapsed / period
    function automatic void model_out(input int c, output bit l, output bit b);
        int h;
        l = 1'b0;
        b = 1'b0;
        h = m_t[c] / m_per[c];
        case (m_mode[c])
            1: l = 1'b1;
            2: l = (h % 2) == 0;
            3: if (m_cnt[c] > 0 && h < 2 * m_cnt[c]) begin
                   l = (h % 2) == 0;
                   b = 1'b1;
               end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0;
            m_per[c]  = 1;
            m_cnt[c]  = 0;
            m_t[c]    = 0;
        end
        m_cyc      = 0;
        m_prev_acc = 1'b0;
    endfunction

    // One clock cycle: check current outputs, drive inputs, advance model
    task automatic step(input bit r, input bit v, input int ch, input int md,
                        input int per, input int cnt);
        bit el, eb, exp_ready, acc, tick;
        @(negedge clk50);
        for (int c = 0; c < NUM_CH; c++) begin
            model_out(c, el, eb);
            check_val($sformatf("led[%0d]", c), 32'(led[c]), 32'(el));
            check_val($sformatf("busy[%0d]", c), 32'(busy[c]), 32'(eb));
        end
        rst               = r;
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_ch     = 3'(ch);
        cfg_if.cfg_mode   = 2'(md);
        cfg_if.cfg_period = PER_W'(per);
        cfg_if.cfg_count  = CNT_W'(cnt);
        #1;
        exp_ready = !r && !m_prev_acc;
        check_val("cfg_ready", 32'(cfg_if.cfg_ready), 32'(exp_ready));

        if (r) begin
            model_reset();
        end else begin
            acc  = v && exp_ready;
            tick = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc && ch == c) begin
                    m_mode[c] = md;
                    m_per[c]  = (per == 0) ? 1 : per;
                    m_cnt[c]  = cnt;
                    m_t[c]    = 0;
                end else if (tick) begin
                    if (m_mode[c] == 2)
                        m_t[c] = (m_t[c] + 1) % (2 * m_per[c]);
                    else if (m_mode[c] == 3 && m_t[c] < 2 * m_cnt[c] * m_per[c])
                        m_t[c] = m_t[c] + 1;
                end
            end
            m_prev_acc = acc;
            m_cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int md, input int per, input int cnt);
        step(1'b0, 1'b1, ch, md, per, cnt);
    endtask

    // Idle until the next cycle is a tick cycle
    task automatic align_to_tick();
        for (int i = 0; i < TICK_DIV && (m_cyc % TICK_DIV) != (TICK_DIV - 1); i++)
            idle(1);
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mode   = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_count  = '0;
        model_reset();
        repeat (3) @(posedge clk50);

        // Reset held, including a write that must be ignored
        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 0, 1, 0, 0);
        idle(8);

        // Steady on, then blink period 2 and period 0 on channel 1
        wr(0, 1, 0, 0);
        wr(1, 1, 0, 0);               // rejected: ready low after acceptance
        idle(3);
        wr(1, 2, 2, 0);
        idle(34);
        wr(1, 2, 0, 0);
        idle(12);

        // Burst of 3 one-tick pulses, then burst with zero count
        wr(0, 3, 1, 3);
        idle(30);
        wr(0, 3, 1, 0);
        idle(6);

        // Write on a tick cycle, and rewrite mid-burst
        align_to_tick();
        wr(0, 2, 3, 0);
        idle(10);
        wr(0, 3, 2, 4);
        idle(13);
        wr(0, 3, 1, 2);
        idle(24);

        // Out-of-range channel, then reset mid-burst
        wr(5, 1, 0, 0);
        idle(4);
        wr(1, 3, 2, 5);
        idle(9);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        idle(6);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int ch;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 9) == 0);
            ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7))
                                             : int'($urandom_range(0, 1));
            step(r, v, ch, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent LED channels (legal 1..8).
REQ-002 Parameter TICK_DIV, default 50000, clk50 cycles per timebase tick (1 ms at 50 MHz); legal >= 2.
REQ-003 Parameter PER_W, default 16, width of per-channel half-period in ticks.
REQ-004 Parameter CNT_W, default 8, width of burst pulse count.
REQ-005 clk50  input  1  system clock, 50 MHz; the single clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  block can accept a configuration write.
REQ-009 cfg_ch  input  3  target channel index.
REQ-010 cfg_mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-011 cfg_period  input  PER_W  half-period in ticks; 0 treated as 1.
REQ-012 cfg_count  input  CNT_W  number of on-pulses for BURST.
REQ-013 led  output  NUM_CH  registered LED drive, bit i = channel i.
REQ-014 busy  output  NUM_CH  bit i high while channel i has a BURST in progress.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 and wraps; tick is high for exactly one cycle per wrap, shared by all channels.
REQ-016 A write is accepted on the cycle where cfg_valid and cfg_ready are both high; cfg_ready is low for exactly the one cycle after an acceptance, high otherwise.
REQ-017 Writes with cfg_ch >= NUM_CH are accepted and discarded without effect.
REQ-018 Per-channel states: OFF, ON, BLINK_HI, BLINK_LO, BURST_HI, BURST_LO; led bit is 1 in ON, BLINK_HI and BURST_HI, else 0.
REQ-019 An accepted write takes effect on the next cycle: phase counter cleared, period and count latched, state set to OFF, ON, BLINK_HI or BURST_HI per mode.
REQ-020 Latency: led bit reflects the new mode one clk50 cycle after acceptance.
REQ-021 BLINK: on each tick the phase counter increments; when it reaches period-1 it clears and the state toggles BLINK_HI <-> BLINK_LO.
REQ-022 BURST: same timing as BLINK; each BURST_LO -> BURST_HI transition decrements remaining count; after the last BURST_LO phase the state goes to OFF.
REQ-023 BURST with cfg_count = 0 enters OFF directly; busy never asserts.
REQ-024 busy bit is high in BURST_HI and BURST_LO only; it falls in the same cycle the state becomes OFF.
REQ-025 A write to a channel in the same cycle as a tick overrides the tick for that channel; other channels process the tick normally.
REQ-026 A write to a channel mid-BLINK or mid-BURST restarts it from phase 0 with the new parameters; no residual count is kept.
REQ-027 Channels are fully independent; phase counters are PER_W bits and never overflow because they clear at period-1.

Reset
REQ-028 While rst is high: prescaler 0, all channels OFF, phase and count registers 0, led all 0, busy all 0, cfg_ready 0.
REQ-029 cfg_ready rises on the first cycle after rst deasserts; the first tick occurs TICK_DIV cycles after rst deasserts.
REQ-030 A write presented during rst is ignored.

Structure
REQ-031 Shared package led_pkg holds the mode encoding, the channel state enum and the mode/channel field widths.
REQ-032 One sub-module, led_channel (state machine, phase counter, burst counter), instantiated NUM_CH times; prescaler and config decode live in led_sequencer.

Verification (TICK_DIV=4, NUM_CH=2)
REQ-033 Reset release, no writes -> led=00, busy=00, cfg_ready=1 from first cycle after reset, tick every 4 cycles.
REQ-034 Write ch0 ON -> led[0]=1 one cycle after acceptance, cfg_ready low exactly that cycle; ch1 unaffected.
REQ-035 Write ch1 BLINK period=2 -> led[1] high 2 ticks, low 2 ticks, repeating (16-cycle period); period=0 gives 1-tick halves.
REQ-036 Write ch0 BURST period=1 count=3 -> exactly 3 one-tick pulses, busy[0] high from acceptance+1 until state returns OFF, then led[0]=0.
REQ-037 Write ch0 BLINK in the cycle tick is high, and rewrite mid-BURST -> phase restarts at 0, tick ignored for ch0 only.
REQ-038 cfg_ch=5 write, and assert rst mid-BURST -> no state change for the first; all outputs return to reset values the cycle after rst.
